// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One radix-2 step per cycle in RUN; FIX applies sign correction and commits HI/LO.
module ex_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o,
  output logic [1:0]       state_o
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod;   // mul: {partial sum, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opnd;   // mul: multiplicand magnitude; div: divisor magnitude
  logic               is_div;
  logic               neg_q;  // product sign (mul) or quotient sign (div)
  logic               neg_r;

  logic op_muldiv, op_signed, op_is_div, in_idle, start, mt_hi, mt_lo, last_step;
  logic sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign op_muldiv = (op_i == OP_MULT) || (op_i == OP_MULTU) ||
                     (op_i == OP_DIV)  || (op_i == OP_DIVU);
  assign op_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign op_is_div = (op_i == OP_DIV)  || (op_i == OP_DIVU);
  assign in_idle   = (state == S_IDLE);
  assign start     = in_idle && !flush_i && op_muldiv;
  assign mt_hi     = in_idle && !flush_i && (op_i == OP_MTHI);
  assign mt_lo     = in_idle && !flush_i && (op_i == OP_MTLO);
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  assign sign_a = op_signed && opa_i[WIDTH-1];
  assign sign_b = op_signed && opb_i[WIDTH-1];
  assign mag_a  = sign_a ? (~opa_i + 1'b1) : opa_i;
  assign mag_b  = sign_b ? (~opb_i + 1'b1) : opb_i;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (flush_i)        state_nxt = S_IDLE;
        else if (last_step) state_nxt = S_FIX;
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy_o  = 1'b0;
    done_o  = 1'b0;
    stall_o = 1'b0;
    case (state)
      S_IDLE: stall_o = op_muldiv && !flush_i;
      S_RUN: begin
        busy_o  = 1'b1;
        stall_o = 1'b1;
      end
      S_FIX: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o = state;

  // Single radix-2 step for each operation
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next;

  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, prod[WIDTH-1:1]};
    div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd};
    // A set top bit means the trial subtraction underflowed: keep the shifted remainder
    div_next  = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      prod   <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      is_div <= op_is_div;
      neg_q  <= sign_a ^ sign_b;
      neg_r  <= sign_a;
      opnd   <= op_is_div ? mag_b : mag_a;
      prod   <= {{WIDTH{1'b0}}, (op_is_div ? mag_a : mag_b)};
    end else if (state == S_RUN && !flush_i) begin
      cnt  <= cnt + 1'b1;
      prod <= is_div ? div_next : mul_next;
    end
  end

  // Sign correction; a zero divisor leaves the dividend in the remainder half
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

  always_comb begin
    prod_fix = neg_q ? (~prod + 1'b1) : prod;
    quo      = prod[WIDTH-1:0];
    rem      = prod[2*WIDTH-1:WIDTH];
    if (is_div) begin
      fix_hi = neg_r ? (~rem + 1'b1) : rem;
      fix_lo = (opnd == '0) ? '1 : (neg_q ? (~quo + 1'b1) : quo);
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (state == S_FIX && !flush_i) begin
      hi_o <= fix_hi;
      lo_o <= fix_lo;
    end else begin
      if (mt_hi) hi_o <= opa_i;
      if (mt_lo) lo_o <= opa_i;
    end
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width (even, >=8).
REQ-002 SHALL have parameter CNT_W, default 6, iteration counter width (2**CNT_W > WIDTH).
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port op_i  in  3  operation: 000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 NOP.
REQ-006 SHALL have port opa_i  in  WIDTH  operand A (multiplicand/dividend/MTHI-MTLO data).
REQ-007 SHALL have port opb_i  in  WIDTH  operand B (multiplier/divisor).
REQ-008 SHALL have port flush_i  in  1  pipeline flush, aborts operation in progress.
REQ-009 SHALL have port hi_o  out  WIDTH  HI register.
REQ-010 SHALL have port lo_o  out  WIDTH  LO register.
REQ-011 SHALL have port busy_o  out  1  high in RUN or FIX.
REQ-012 SHALL have port done_o  out  1  high exactly in FIX cycle.
REQ-013 SHALL have port stall_o  out  1  pipeline stall request.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, FIX; RUN advances one radix-2 step per cycle.
REQ-015 In IDLE with op_i in {MULT,MULTU,DIV,DIVU} and flush_i low, SHALL latch opa_i/opb_i/op_i, clear counter, enter RUN at next edge.
REQ-016 Signed ops SHALL latch operand magnitudes and record result signs (product: sign xor; quotient: sign xor; remainder: dividend sign).
REQ-017 RUN SHALL last exactly WIDTH cycles (counter 0..WIDTH-1), then enter FIX.
REQ-018 Multiply SHALL be shift-add over unsigned magnitudes producing 2*WIDTH-bit product.
REQ-019 Divide SHALL be restoring division over unsigned magnitudes producing WIDTH-bit quotient and remainder.
REQ-020 FIX SHALL apply sign correction (two's complement negate), then at FIX exit edge write HI=product[2W-1:W], LO=product[W-1:0] (mul) or HI=remainder, LO=quotient (div), and return to IDLE.
REQ-021 Latency: op accepted at edge E; done_o high between E+WIDTH and E+WIDTH+1; new hi_o/lo_o visible after E+WIDTH+1.
REQ-022 Divisor zero (DIV or DIVU) SHALL yield LO=all ones, HI=opa_i unmodified, same latency.
REQ-023 DIV of most-negative by -1 SHALL yield LO=most-negative, HI=0.
REQ-024 MTHI/MTLO in IDLE SHALL write opa_i to HI/LO at next edge, zero extra latency, busy_o stays low.
REQ-025 op_i SHALL be ignored while busy_o high; HI/LO change only at FIX exit or MTHI/MTLO.
REQ-026 flush_i high in RUN or FIX SHALL return FSM to IDLE at next edge, HI/LO unchanged, done_o low thereafter; flush_i in FIX wins over HI/LO write.
REQ-027 flush_i high in IDLE SHALL suppress acceptance of any op that cycle, including MTHI/MTLO.
REQ-028 stall_o SHALL be combinational: high in RUN, low in FIX, high in IDLE when op_i is mul/div and flush_i low; low otherwise.
REQ-029 hi_o/lo_o SHALL be direct register outputs (no combinational bypass).
REQ-030 Back-to-back: new mul/div op SHALL be acceptable in first IDLE cycle after FIX.

Reset
REQ-031 rst low SHALL asynchronously force state IDLE, counter 0, hi_o=0, lo_o=0, busy_o=0, done_o=0; stall_o follows REQ-028 from IDLE.
REQ-032 rst asserted mid-operation SHALL discard the operation; no HI/LO write after release.
REQ-033 First edge after rst release SHALL be able to accept an op.

Verification (WIDTH=32)
REQ-034 MULT opa=0xFFFFFFFD, opb=7 -> done_o at cycle 32 after accept, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-035 MULTU opa=opb=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; stall_o high 33 cycles incl. accept cycle, low in FIX.
REQ-036 DIV opa=0xFFFFFFF9 (-7), opb=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-037 DIVU opa=5, opb=0 -> LO=0xFFFFFFFF, HI=5, latency 33 cycles.
REQ-038 MTHI 0x12345678 then MTLO 0x9ABCDEF0 consecutive -> hi_o/lo_o updated one edge each, busy_o never high.
REQ-039 MULT started, flush_i at RUN cycle 10 (or rst low at cycle 10) -> IDLE next edge (immediately for rst), HI/LO retain prior values (0 after reset), done_o never pulses.
